// File: rtl/seg7_serializer.sv
// Streams a parallel segment word to a serial-in shift-register chain driving a 7-segment board.
// Optional macro SEG7_SERIALIZER_START_SYNC_EN adds a two-flop synchronizer on start.
module seg7_serializer #(
  parameter int DATA_BITS       = 64,
  parameter int DATA_COUNT_BITS = 6,
  parameter int DIR             = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] pdata,
  output logic                 s_clk,
  output logic                 s_clrn,
  output logic                 sout,
  output logic                 en
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  localparam logic [DATA_COUNT_BITS-1:0] LAST_BIT = DATA_COUNT_BITS'(DATA_BITS - 1);

  logic [0:0]                 state;
  logic [DATA_BITS-1:0]       shreg;
  logic [DATA_BITS-1:0]       shifted;
  logic [DATA_COUNT_BITS-1:0] cnt;
  logic                       phase;
  logic                       start_q;
  logic                       start_s;
  logic                       rise;

`ifdef SEG7_SERIALIZER_START_SYNC_EN
  logic [1:0] sync;

  // start may come from another clock domain, so resynchronize before edge detection
  always_ff @(posedge clk) begin
    if (!rst) sync <= 2'b00;
    else      sync <= {sync[0], start};
  end

  assign start_s = sync[1];
`else
  assign start_s = start;
`endif

  assign rise = start_s & ~start_q;

  // Bits move toward the output end with zero fill, so an idle register leaves sout low
  always_comb begin
    shifted = shreg;
    if (DIR == 0) shifted = shreg << 1;
    else          shifted = shreg >> 1;
  end

  assign sout = (DIR == 0) ? shreg[DATA_BITS-1] : shreg[0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
      phase   <= 1'b0;
      start_q <= 1'b0;
      s_clk   <= 1'b0;
      s_clrn  <= 1'b0;
      en      <= 1'b0;
    end else begin
      start_q <= start_s;
      s_clrn  <= 1'b1;
      case (state)
        IDLE: begin
          s_clk <= 1'b0;
          en    <= 1'b1;
          if (rise) begin
            shreg <= pdata;
            cnt   <= '0;
            phase <= 1'b0;
            en    <= 1'b0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // phase 0 is data setup; phase 1 holds s_clk high for the external sampling edge
          if (!phase) begin
            phase <= 1'b1;
            s_clk <= 1'b1;
          end else begin
            phase <= 1'b0;
            s_clk <= 1'b0;
            shreg <= shifted;
            cnt   <= cnt + DATA_COUNT_BITS'(1);
            if (cnt == LAST_BIT) begin
              state <= IDLE;
              en    <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          s_clk <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_serializer.sv
// Scoreboard bench for seg7_serializer: MSB-first and LSB-first instances share stimulus,
// expected serial bits are queued at launch and popped on each s_clk rising edge.
module tb_seg7_serializer;

  localparam int N = 64;
`ifdef SEG7_SERIALIZER_START_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] pdata = '0;

  logic s_clk0, s_clrn0, sout0, en0;
  logic s_clk1, s_clrn1, sout1, en1;

  int   checks = 0;
  int   errors = 0;
  int   rises0 = 0;
  int   rises1 = 0;
  int   run = 0;
  int   last_run = 0;
  logic prev0 = 1'b0;
  logic prev1 = 1'b0;
  logic e0, e1;
  logic q0[$];
  logic q1[$];

  seg7_serializer #(.DATA_BITS(N), .DATA_COUNT_BITS(6), .DIR(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .pdata(pdata),
    .s_clk(s_clk0), .s_clrn(s_clrn0), .sout(sout0), .en(en0)
  );

  seg7_serializer #(.DATA_BITS(N), .DATA_COUNT_BITS(6), .DIR(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .pdata(pdata),
    .s_clk(s_clk1), .s_clrn(s_clrn1), .sout(sout1), .en(en1)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected bit order: MSB first for DIR=0, LSB first for DIR=1
  task automatic push_frame(input logic [N-1:0] word);
    for (int i = 0; i < N; i++) begin
      q0.push_back(word[N-1-i]);
      q1.push_back(word[i]);
    end
  endtask

  task automatic apply_stimulus(input logic [N-1:0] word, input bit hold);
    pdata = word;
    start = 1'b1;
    push_frame(word);
    repeat (LAT - 1) @(negedge clk);
    check_output("en_before_fall", en0, 1'b1);
    @(negedge clk);
    check_output("en_fall_latency", en0, 1'b0);
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_frame_end();
    int guard = 0;
    while (en0 !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check_output("frame_end_timeout", guard < 2000, 1'b1);
    @(posedge clk);
    #1;
    check_output("en_low_cycles", last_run, 2 * N);
    check_output("queue0_empty", q0.size(), 0);
    check_output("queue1_empty", q1.size(), 0);
    check_output("idle_sout0", sout0, 1'b0);
    check_output("idle_sclk0", s_clk0, 1'b0);
    check_output("en1_matches", en1, 1'b1);
  endtask

  // Scoreboard monitor: each s_clk rising edge consumes one expected bit
  always @(negedge clk) begin
    if (s_clk0 === 1'b1 && prev0 === 1'b0) begin
      rises0++;
      check_output("edge0_expected", q0.size() != 0, 1'b1);
      if (q0.size() != 0) begin
        e0 = q0.pop_front();
        check_output("bit_dir0", sout0, e0);
      end
    end
    if (s_clk1 === 1'b1 && prev1 === 1'b0) begin
      rises1++;
      check_output("edge1_expected", q1.size() != 0, 1'b1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        check_output("bit_dir1", sout1, e1);
      end
    end
    prev0 = s_clk0;
    prev1 = s_clk1;
    if (en0 === 1'b0) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int r;
    int guard;

    repeat (3) @(negedge clk);
    check_output("reset_sclrn", s_clrn0, 1'b0);
    check_output("reset_en", en0, 1'b0);
    check_output("reset_sclk", s_clk0, 1'b0);
    check_output("reset_sout", sout0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_output("release_sclrn", s_clrn0, 1'b1);
    check_output("release_en", en0, 1'b1);
    repeat (2) @(negedge clk);

    // Frame A: endpoint bits set, both orders see 1 ... 1
    apply_stimulus(64'h8000_0000_0000_0001, 1'b0);
    wait_frame_end();
    check_output("frameA_rises", rises0, N);

    // Frame B: LSB-first stream of A5 is 1,0,1,0,0,1,0,1 then zeros
    repeat (2) @(negedge clk);
    apply_stimulus(64'h0000_0000_0000_00A5, 1'b0);
    wait_frame_end();
    check_output("frameB_rises1", rises1, 2 * N);

    // Frame C: a second rise and pdata change mid-frame must be ignored
    repeat (2) @(negedge clk);
    apply_stimulus(64'h0123_4567_89AB_CDEF, 1'b0);
    repeat (28) @(negedge clk);
    start = 1'b1;
    pdata = '1;
    wait_frame_end();
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_output("frameC_no_restart", rises0, 3 * N);

    // Frame D: start held high gives exactly one frame, then a fresh rise gives another
    apply_stimulus(64'hF0F0_1234_5678_0F0F, 1'b1);
    wait_frame_end();
    repeat (500 - 2 * N) @(negedge clk);
    check_output("held_one_frame", rises0, 4 * N);
    check_output("held_en_idle", en0, 1'b1);
    start = 1'b0;
    @(negedge clk);
    apply_stimulus(64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    wait_frame_end();
    check_output("second_frame_rises", rises0, 5 * N);

    // Frame E: reset near bit 20 abandons the frame
    repeat (2) @(negedge clk);
    r = rises0;
    apply_stimulus('1, 1'b0);
    guard = 0;
    while (rises0 < r + 20 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_output("bit20_timeout", guard < 200, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check_output("midreset_sclk", s_clk0, 1'b0);
    check_output("midreset_sout", sout0, 1'b0);
    check_output("midreset_sclrn", s_clrn0, 1'b0);
    check_output("midreset_en", en0, 1'b0);
    q0.delete();
    q1.delete();
    rst = 1'b1;
    r = rises0;
    @(negedge clk);
    check_output("post_reset_en", en0, 1'b1);
    check_output("post_reset_sclrn", s_clrn0, 1'b1);
    repeat (10) @(negedge clk);
    check_output("post_reset_no_edges", rises0, r);
    check_output("post_reset_sout1", sout1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
